sink: RTL and testbench
=======================

SINK -- requirements
Module: sink

Interface
REQ-001 SHALL expose parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL expose parameter DEPTH, default 8, FIFO entries; power of two, >= 4.
REQ-003 SHALL expose parameter ADDR, default 3, pointer width, equal to log2(DEPTH).
REQ-004 SHALL expose parameter AFULL_THRESH, default DEPTH-2, almost-full level; used only when SINK_AFULL_EN is defined.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 sink_valid  in  1  upstream word present on sink_data.
REQ-008 sink_data  in  WIDTH  upstream word.
REQ-009 sink_ready  out  1  block can accept a word this cycle.
REQ-010 rd_en  in  1  local consumer requests one word.
REQ-011 rd_data  out  WIDTH  word returned for an accepted read.
REQ-012 rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-013 fifo_full  out  1  count == DEPTH.
REQ-014 fifo_empty  out  1  count == 0.
REQ-015 count  out  ADDR+1  stored-word occupancy, 0..DEPTH.
REQ-016 almost_full  out  1  present only with SINK_AFULL_EN; count >= AFULL_THRESH.

Function
REQ-017 Accept SHALL occur at a rising edge where sink_valid && sink_ready; sink_data written at wr_ptr, wr_ptr incremented modulo DEPTH.
REQ-018 sink_ready SHALL be combinational: !fifo_full (baseline); independent of sink_valid.
REQ-019 No accept when sink_valid low or sink_ready low; the upstream word is not consumed and must be held by upstream.
REQ-020 Read accepted when rd_en && !fifo_empty: rd_data <= mem[rd_ptr], rd_ptr incremented modulo DEPTH, rd_valid high the next cycle only.
REQ-021 rd_en while empty SHALL be ignored: no pointer change, rd_valid low, rd_data holds its last value.
REQ-022 Read latency SHALL be one cycle from rd_en sample to rd_valid/rd_data.
REQ-023 Continuous rd_en with data present SHALL give one word per cycle, rd_valid held high.
REQ-024 count: +1 on accept only, -1 on read only, unchanged on both or neither.
REQ-025 Simultaneous accept and read when empty: read is ignored (empty), the write lands, and count becomes 1.
REQ-026 Simultaneous accept and read when full: impossible, since sink_ready is low; the read proceeds and count becomes DEPTH-1.
REQ-027 All DEPTH entries SHALL be usable; pointers wrap DEPTH-1 -> 0 with no lost or duplicated word.
REQ-028 Output ordering SHALL be strictly first-in first-out.
REQ-029 fifo_full, fifo_empty and count SHALL be registered-state-derived, with no dependency on the current cycle's inputs.

Reset
REQ-030 With rst high at a rising edge, the block SHALL clear wr_ptr, rd_ptr, count, rd_valid and rd_data to 0.
REQ-031 After reset: fifo_empty=1, fifo_full=0, sink_ready=1, almost_full=0.
REQ-032 Memory contents SHALL NOT require reset; words are unreadable until written.
REQ-033 Reset mid-operation SHALL discard all stored words; an accept or read in the reset cycle SHALL have no effect.

Configuration
REQ-034 Macro SINK_AFULL_EN defined: the block SHALL add the almost_full port, and sink_ready = (count < AFULL_THRESH), reserving headroom for upstream skid.
REQ-035 Macro SINK_AFULL_EN undefined: no almost_full port, and sink_ready = !fifo_full per REQ-018.

Verification
REQ-036 All scenarios use WIDTH=8 and DEPTH=4. Reset, then present 0x11,0x22,0x33,0x44 with sink_valid high -> four accepts, count=4, fifo_full=1, sink_ready=0; a 5th word 0x55 is held and not accepted.
REQ-037 From full, pulse rd_en once -> next cycle rd_data=0x11, rd_valid=1, count=3, sink_ready=1, and 0x55 is accepted the following edge.
REQ-038 Hold rd_en for 4 cycles after loading 0xA0..0xA3 -> rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then fifo_empty=1 and rd_valid=0.
REQ-039 rd_en high while empty for 3 cycles -> rd_valid stays 0, count stays 0, rd_data unchanged.
REQ-040 Push and pop simultaneously for 10 cycles with count=2 -> count stays 2, pointers wrap, data order preserved.
REQ-041 Assert rst with count=3 -> next cycle count=0, fifo_empty=1, rd_valid=0. With SINK_AFULL_EN and AFULL_THRESH=2, two accepts -> almost_full=1 and sink_ready=0.

Source files
------------

// File: rtl/sink.sv
// Synchronous FIFO sink: accepts upstream words under valid/ready and returns them in order to a local reader.
// Optional SINK_AFULL_EN adds almost_full and throttles sink_ready at AFULL_THRESH to leave room for upstream skid.
module sink #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR         = 3,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sink_valid,
    input  logic [WIDTH-1:0] sink_data,
    output logic             sink_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             fifo_full,
    output logic             fifo_empty,
`ifdef SINK_AFULL_EN
    output logic             almost_full,
`endif
    output logic [ADDR:0]    count
);

    localparam logic [ADDR:0] FULL_COUNT = (ADDR + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  wr_ptr;
    logic [ADDR-1:0]  rd_ptr;
    logic             accept;
    logic             rd_fire;

    // Status flags depend only on registered occupancy, never on this cycle's inputs.
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

`ifdef SINK_AFULL_EN
    assign almost_full = (count >= (ADDR + 1)'(AFULL_THRESH));
    assign sink_ready  = (count <  (ADDR + 1)'(AFULL_THRESH));
`else
    assign sink_ready  = !fifo_full;
`endif

    assign accept  = sink_valid && sink_ready;
    assign rd_fire = rd_en && !fifo_empty;

    // NOTE: storage has no reset; every entry is written before the read pointer can reach it.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wr_ptr] <= sink_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_fire;
            case ({accept, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sink.sv
// Self-checking bench for sink (WIDTH=8, DEPTH=4): a queue scoreboard predicts every accept/read each cycle.
// Builds with or without SINK_AFULL_EN; the model's ready limit follows the macro.
module tb_sink;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int ADDR  = 2;
`ifdef SINK_AFULL_EN
    localparam int READY_LIMIT = DEPTH - 2;
`else
    localparam int READY_LIMIT = DEPTH;
`endif

    logic             clk;
    logic             rst;
    logic             sink_valid;
    logic [WIDTH-1:0] sink_data;
    logic             sink_ready;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ADDR:0]    count;
`ifdef SINK_AFULL_EN
    logic             almost_full;
`endif

    sink #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ADDR (ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sink_valid (sink_valid),
        .sink_data  (sink_data),
        .sink_ready (sink_ready),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
`ifdef SINK_AFULL_EN
        .almost_full(almost_full),
`endif
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: words pushed when an accept is predicted, popped when a read is predicted.
    logic [WIDTH-1:0] sb_q[$];
    int               m_count   = 0;
    logic [WIDTH-1:0] m_rd_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance one clock with the inputs already driven; predict, then compare after the edge.
    task automatic step();
        logic acc;
        logic rd;
        if (!rst) check("sink_ready", sink_ready, (m_count < READY_LIMIT));
        acc = !rst && sink_valid && (m_count < READY_LIMIT);
        rd  = !rst && rd_en && (m_count != 0);
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            m_rd_data = '0;
        end else begin
            if (rd) m_rd_data = sb_q.pop_front();
            if (acc) sb_q.push_back(sink_data);
        end
        m_count = sb_q.size();
        check("rd_valid", rd_valid, rd);
        check("rd_data", rd_data, m_rd_data);
        check("count", count, m_count);
        check("fifo_empty", fifo_empty, (m_count == 0));
        check("fifo_full", fifo_full, (m_count == DEPTH));
`ifdef SINK_AFULL_EN
        check("almost_full", almost_full, (m_count >= READY_LIMIT));
`endif
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        sink_valid = 1'b1;
        sink_data  = d;
        rd_en      = 1'b0;
        step();
        sink_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        sink_valid = 1'b0;
        sink_data  = '0;
        rd_en      = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("ready_after_reset", sink_ready, 1);

        // Fill to full, then hold a fifth word that must not be taken.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        sink_valid = 1'b1;
        sink_data  = 8'h55;
        step();
        step();

        // Single read from full frees a slot; the held word lands on the next edge.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        sink_valid = 1'b0;
        rd_en      = 1'b1;
        repeat (6) step();
        rd_en = 1'b0;

        // Back-to-back reads, one word per cycle.
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        rd_en = 1'b1;
        repeat (4) step();
        rd_en = 1'b0;
        step();

        // Reads while empty are ignored and rd_data holds.
        rd_en = 1'b1;
        repeat (3) step();
        rd_en = 1'b0;

        // Simultaneous push and pop at occupancy 2, wrapping the pointers.
        push(8'h01);
        push(8'h02);
        sink_valid = 1'b1;
        rd_en      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sink_data = 8'(8'h10 + i);
            step();
        end
        sink_valid = 1'b0;
        repeat (3) step();
        rd_en = 1'b0;

        // Reset mid-operation discards contents; accept/read in the reset cycle are void.
        push(8'hC0);
        push(8'hC1);
        push(8'hC2);
        rst        = 1'b1;
        sink_valid = 1'b1;
        sink_data  = 8'hEE;
        rd_en      = 1'b1;
        step();
        rst        = 1'b0;
        sink_valid = 1'b0;
        rd_en      = 1'b0;
        step();
        check("empty_after_midreset", fifo_empty, 1);

        // Two accepts: throttles ready when almost-full is enabled.
        push(8'hD0);
        push(8'hD1);
        sink_valid = 1'b1;
        sink_data  = 8'hD2;
        step();
        sink_valid = 1'b0;
        rd_en      = 1'b1;
        repeat (4) step();
        rd_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
